// File: rtl/sub_bus_master_pkg.sv
// Shared definitions for the FM-7 sub-system bus master and address decoder.
package sub_bus_master_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CS_W   = 4;

    localparam logic [ADDR_W-1:0] RAM1_BASE    = 16'hC000;
    localparam logic [ADDR_W-1:0] RAM1_LIMIT   = 16'hC7FF;
    localparam logic [ADDR_W-1:0] RAM2_BASE    = 16'hC800;
    localparam logic [ADDR_W-1:0] RAM2_LIMIT   = 16'hCFFF;
    localparam logic [ADDR_W-1:0] CHROM_BASE   = 16'hD800;
    localparam logic [ADDR_W-1:0] CHROM_LIMIT  = 16'hDFFF;
    localparam logic [ADDR_W-1:0] MONROM_BASE  = 16'hE000;
    localparam logic [ADDR_W-1:0] MONROM_LIMIT = 16'hFFFF;

    typedef enum logic [2:0] {
        REGION_RAM1,
        REGION_RAM2,
        REGION_CHROM,
        REGION_MONROM,
        REGION_NONE
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_e;

    // Address falls inside [base, limit]
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

    // Active-low chip-select vector {MONROM, CHROM, RAM2, RAM1} for a region
    function automatic logic [CS_W-1:0] region_cs_n(input region_e region);
        case (region)
            REGION_RAM1:   return 4'b1110;
            REGION_RAM2:   return 4'b1101;
            REGION_CHROM:  return 4'b1011;
            REGION_MONROM: return 4'b0111;
            default:       return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sub_addr_decode.sv
// Combinational sub-system address decoder: address -> region and ROM flag.
module sub_addr_decode
    import sub_bus_master_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_i,
    output region_e           region_c,
    output logic              is_rom_c
);

    // Map address onto one of the fixed memory windows
    always_comb begin
        region_c = REGION_NONE;
        if (in_window(addr_i, RAM1_BASE, RAM1_LIMIT)) begin
            region_c = REGION_RAM1;
        end else if (in_window(addr_i, RAM2_BASE, RAM2_LIMIT)) begin
            region_c = REGION_RAM2;
        end else if (in_window(addr_i, CHROM_BASE, CHROM_LIMIT)) begin
            region_c = REGION_CHROM;
        end else if (in_window(addr_i, MONROM_BASE, MONROM_LIMIT)) begin
            region_c = REGION_MONROM;
        end
        is_rom_c = (region_c == REGION_CHROM) || (region_c == REGION_MONROM);
    end

endmodule

// File: rtl/sub_bus_master.sv
// Single-beat bus initiator sequencing SETUP/STROBE/HOLD/DONE on the sub-system memory bus.
module sub_bus_master
    import sub_bus_master_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic              CLKSYS,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic              BUSY,
    output logic              ACK,
    output logic [DATA_W-1:0] RDATA,
    output logic              ERR,
    output logic [ADDR_W-1:0] SADDRBUS,
    output logic [DATA_W-1:0] SDATABUS_out,
    input  logic [DATA_W-1:0] SDATABUS_in,
    output logic              SRAM1CSn,
    output logic              SRAM2CSn,
    output logic              SROMDn,
    output logic              SROMSELn,
    output logic              SWTQEn,
    output logic              SRDQEn
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    region_e           region_q, region_d;
    logic              rom_q, rom_d;
    logic [ADDR_W-1:0] saddr_q, saddr_d;
    logic [DATA_W-1:0] sdout_q, sdout_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic [CS_W-1:0]   cs_n_q, cs_n_d;
    logic              wt_n_q, wt_n_d;
    logic              rd_n_q, rd_n_d;

    region_e           dec_region;
    logic              dec_rom;

    sub_addr_decode u_decode (
        .addr_i   (ADDR),
        .region_c (dec_region),
        .is_rom_c (dec_rom)
    );

    // State and registered bus outputs
    always_ff @(posedge CLKSYS) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            region_q <= REGION_NONE;
            rom_q    <= 1'b0;
            saddr_q  <= '0;
            sdout_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            cs_n_q   <= '1;
            wt_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            region_q <= region_d;
            rom_q    <= rom_d;
            saddr_q  <= saddr_d;
            sdout_q  <= sdout_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            cs_n_q   <= cs_n_d;
            wt_n_q   <= wt_n_d;
            rd_n_q   <= rd_n_d;
        end
    end

    // Next state; bus outputs are derived from the upcoming state so they register in step with it
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        region_d = region_q;
        rom_d    = rom_q;
        saddr_d  = saddr_q;
        sdout_d  = sdout_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    state_d  = ST_SETUP;
                    we_d     = WE;
                    region_d = dec_region;
                    rom_d    = dec_rom;
                    saddr_d  = ADDR;
                    if (WE) begin
                        sdout_d = WDATA;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = CNT_W'(STROBE_CYCLES - 1);
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_DONE;
                err_d   = (region_q == REGION_NONE) || (we_q && rom_q);
                if (!we_q) begin
                    rdata_d = (region_q == REGION_NONE) ? 8'hFF : SDATABUS_in;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        ack_d  = (state_d == ST_DONE);
        cs_n_d = '1;
        if (state_d inside {ST_SETUP, ST_STROBE, ST_HOLD}) begin
            cs_n_d = region_cs_n(region_d);
        end
        wt_n_d = !((state_d == ST_STROBE) && we_d && !rom_d && (region_d != REGION_NONE));
        rd_n_d = !((state_d == ST_STROBE) && !we_d && (region_d != REGION_NONE));
    end

    assign BUSY         = busy_q;
    assign ACK          = ack_q;
    assign RDATA        = rdata_q;
    assign ERR          = err_q;
    assign SADDRBUS     = saddr_q;
    assign SDATABUS_out = sdout_q;
    assign SRAM1CSn     = cs_n_q[0];
    assign SRAM2CSn     = cs_n_q[1];
    assign SROMDn       = cs_n_q[2];
    assign SROMSELn     = cs_n_q[3];
    assign SWTQEn       = wt_n_q;
    assign SRDQEn       = rd_n_q;

endmodule

// File: doc/sub_bus_master.md
# sub_bus_master

Bus initiator for the FM-7 sub-system memory bus. Accepts single-beat read/write requests from a host port (loader, debugger or main-CPU bridge), decodes the 16-bit address into the sub-system chip selects, and sequences address, chip-select, strobe and data phases to the sub-system RAM/ROM responders. Returns read data with a one-cycle acknowledge. Sits between the host-side arbiter and the sub-system memory block, in place of the sub-CPU when the sub-CPU is halted.

## Interface
- STROBE_CYCLES, 1: cycles the read/write strobe is held low (1–15).
- CLKSYS  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  1  request; sampled only while BUSY=0.
- WE  in  1  1=write, 0=read; sampled with REQ.
- ADDR  in  16  request address; sampled with REQ.
- WDATA  in  8  write data; sampled with REQ.
- BUSY  out  1  transaction in progress.
- ACK  out  1  one-cycle completion pulse.
- RDATA  out  8  read data; valid from ACK until next ACK.
- ERR  out  1  status of the completed transaction, valid with ACK.
- SADDRBUS  out  16  sub-system address.
- SDATABUS_out  out  8  data toward memory.
- SDATABUS_in  in  8  data from memory (responder output).
- SRAM1CSn, SRAM2CSn, SROMDn, SROMSELn  out  1 each  active-low chip selects.
- SWTQEn, SRDQEn  out  1 each  active-low write/read strobes.

## Operation
- Address map: RAM1 $C000–$C7FF (SRAM1CSn); RAM2 $C800–$CFFF (SRAM2CSn); character ROM $D800–$DFFF (SROMDn); monitor ROM $E000–$FFFF (SROMSELn). All else unmapped.
- At most one chip select low at any time; all high outside SETUP/STROBE/HOLD.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: REQ=1 latches WE/ADDR/WDATA, decodes region, -> SETUP. BUSY=1 from next cycle.
- SETUP: SADDRBUS=latched address, selected CS low, SDATABUS_out=WDATA on writes; -> STROBE.
- STROBE: SRDQEn (read) or SWTQEn (write) low; counter runs STROBE_CYCLES cycles; -> HOLD.
- HOLD: strobe high, CS still low; on read, RDATA <= SDATABUS_in; -> DONE.
- DONE: ACK=1, CS high, BUSY=1; -> IDLE (BUSY=0 next cycle).
- Write to ROM region: no strobe asserted (CS still cycles), ERR=1.
- Unmapped access: no CS, no strobe, read RDATA=$FF, ERR=1.
- REQ while BUSY=1: ignored, not queued.
- Reset values: BUSY=0, ACK=0, ERR=0, RDATA=$00, SADDRBUS=$0000, SDATABUS_out=$00, all CS and strobes 1, state IDLE.
- RST mid-transaction: abort; outputs at reset values the cycle after RST sampled; no ACK issued.

## Timing
- Request accepted at edge T; SETUP at T+1, STROBE T+2..T+1+STROBE_CYCLES, HOLD next, ACK in the cycle after HOLD.
- STROBE_CYCLES=1: ACK high in cycle T+4; next REQ acceptable at T+5.
- SADDRBUS and SDATABUS_out stable from SETUP through HOLD; change only in IDLE on acceptance.
- Read capture relies on responder registered output valid one cycle after strobe edge; HOLD captures it.
- REQ held high continuously: back-to-back transactions every 4+STROBE_CYCLES cycles.

## Structure
- Shared package: region base/limit constants, region enum (RAM1, RAM2, CHROM, MONROM, NONE), state enum.
- One sub-module natural: sub_addr_decode (combinational ADDR -> region, is_rom), reusable by the sub-CPU side.
- Strobe counter 4 bits.

## Test plan
- Write $5A to $C010, read $C010 with STROBE_CYCLES=1 -> SRAM1CSn low only, SWTQEn low one cycle at T+2, ACK at T+4, RDATA=$5A, ERR=0.
- Write $A5 to $C810 then read $C010 and $C810 -> RAM1 value unchanged, RAM2 returns $A5; SRAM1CSn never low during RAM2 access.
- Read $E000 and $D800 -> SROMSELn/SROMDn low respectively, RDATA equals ROM image bytes; write $00 to $E000 -> ERR=1, SWTQEn never low, ROM contents unchanged.
- Read $0100 -> no CS/strobe asserted, RDATA=$FF, ERR=1, ACK at T+4.
- STROBE_CYCLES=3, REQ held high for two reads -> strobe low 3 cycles each, ACKs 7 cycles apart, second request not accepted before first ACK.
- Assert RST during STROBE of a write -> all CS/strobes high next cycle, no ACK, BUSY=0, target RAM byte unwritten.
